// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, next-PC selects
// and memory address selects as seen by the fetch unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_RST_VEC  = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_INT_PUSH = 3'd4,
        ST_INT_VEC  = 3'd5
    } fetch_state_t;

    localparam logic [2:0] PC_SRC_PLUS1  = 3'b000;
    localparam logic [2:0] PC_SRC_PLUS2  = 3'b001;
    localparam logic [2:0] PC_SRC_BRANCH = 3'b010;
    localparam logic [2:0] PC_SRC_STACK  = 3'b011;
    localparam logic [2:0] PC_SRC_RSTVEC = 3'b100;
    localparam logic [2:0] PC_SRC_INTVEC = 3'b101;

    localparam logic [1:0] ADDR_PC   = 2'b00;
    localparam logic [1:0] ADDR_PC1  = 2'b01;
    localparam logic [1:0] ADDR_ZERO = 2'b10;
    localparam logic [1:0] ADDR_ONE  = 2'b11;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch control FSM: reset-vector load, opcode/immediate fetch, PC update
// and interrupt entry. Sole writer of PC, IR and imm in the fetch unit.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_ready,
    input  logic       hazard_stall,
    input  logic       dec_two_byte,
    input  logic       br_taken,
    input  logic       ret_req,
    input  logic       rti,
    input  logic       intr_req,
    output logic       pc_write,
    output logic       ir_write,
    output logic       imm_write,
    output logic       stall,
    output logic [2:0] pc_src,
    output logic [1:0] mem_addr_sel,
    output logic       push_pc,
    output logic       intr_ack,
    output logic       in_isr
);

    fetch_state_t state_q, state_d;
    logic         in_isr_q, in_isr_d;

    logic       pc_write_s, ir_write_s, imm_write_s, stall_s;
    logic       push_pc_s, intr_ack_s, mem_wait_s;
    logic [2:0] pc_src_s;
    logic [1:0] addr_sel_s;

    // State and interrupt-service flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RST_VEC;
            in_isr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_isr_q <= in_isr_d;
        end
    end

    // Next-state and raw output decode
    always_comb begin
        state_d     = state_q;
        in_isr_d    = in_isr_q;
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        imm_write_s = 1'b0;
        push_pc_s   = 1'b0;
        intr_ack_s  = 1'b0;
        mem_wait_s  = 1'b0;
        pc_src_s    = PC_SRC_PLUS1;
        addr_sel_s  = ADDR_PC;
        case (state_q)
            ST_RST_VEC: begin
                mem_wait_s = 1'b1;
                addr_sel_s = ADDR_ZERO;
                if (mem_ready) begin
                    pc_src_s   = PC_SRC_RSTVEC;
                    pc_write_s = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_RST_VEC;
                end
            end
            ST_FETCH: begin
                mem_wait_s = 1'b1;
                // Interrupt entry leaves IR untouched so the pushed PC still
                // points at the instruction that was about to be fetched.
                if (intr_req && !in_isr_q) begin
                    state_d = ST_INT_PUSH;
                end else if (mem_ready && !hazard_stall) begin
                    ir_write_s = 1'b1;
                    state_d    = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_two_byte) begin
                    mem_wait_s = 1'b1;
                    addr_sel_s = ADDR_PC1;
                    if (mem_ready && !hazard_stall) begin
                        imm_write_s = 1'b1;
                        state_d     = ST_EXEC;
                    end else begin
                        state_d = ST_DECODE;
                    end
                end else if (!hazard_stall) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_EXEC: begin
                if (!hazard_stall) begin
                    pc_write_s = 1'b1;
                    state_d    = ST_FETCH;
                    if (ret_req) begin
                        pc_src_s = PC_SRC_STACK;
                    end else if (br_taken) begin
                        pc_src_s = PC_SRC_BRANCH;
                    end else if (dec_two_byte) begin
                        pc_src_s = PC_SRC_PLUS2;
                    end else begin
                        pc_src_s = PC_SRC_PLUS1;
                    end
                    if (ret_req && rti) begin
                        in_isr_d = 1'b0;
                    end else begin
                        in_isr_d = in_isr_q;
                    end
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_INT_PUSH: begin
                push_pc_s  = 1'b1;
                intr_ack_s = 1'b1;
                state_d    = ST_INT_VEC;
            end
            ST_INT_VEC: begin
                pc_src_s   = PC_SRC_INTVEC;
                pc_write_s = 1'b1;
                in_isr_d   = 1'b1;
                state_d    = ST_FETCH;
            end
            default: begin
                state_d = ST_RST_VEC;
            end
        endcase
        stall_s = hazard_stall | (mem_wait_s & ~mem_ready);
    end

    // Outputs are held at zero for as long as reset is asserted
    always_comb begin
        if (rst) begin
            pc_write     = 1'b0;
            ir_write     = 1'b0;
            imm_write    = 1'b0;
            stall        = 1'b0;
            pc_src       = 3'b000;
            mem_addr_sel = 2'b00;
            push_pc      = 1'b0;
            intr_ack     = 1'b0;
            in_isr       = 1'b0;
        end else begin
            pc_write     = pc_write_s;
            ir_write     = ir_write_s;
            imm_write    = imm_write_s;
            stall        = stall_s;
            pc_src       = pc_src_s;
            mem_addr_sel = addr_sel_s;
            push_pc      = push_pc_s;
            intr_ack     = intr_ack_s;
            in_isr       = in_isr_q;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Cycle-by-cycle check of fetch_sequencer against a behavioural model of
// the fetch/decode/execute/interrupt sequence, directed then randomized.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_ready = 1'b0, hazard_stall = 1'b0, dec_two_byte = 1'b0;
    logic       br_taken = 1'b0, ret_req = 1'b0, rti = 1'b0, intr_req = 1'b0;
    logic       pc_write, ir_write, imm_write, stall, push_pc, intr_ack, in_isr;
    logic [2:0] pc_src;
    logic [1:0] mem_addr_sel;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: where the sequence is (0 reset-vector load, 1 opcode fetch,
    // 2 decode/immediate, 3 execute, 4 push, 5 vector) and the ISR flag.
    int phase   = 0;
    bit isr_flg = 1'b0;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .hazard_stall(hazard_stall),
        .dec_two_byte(dec_two_byte), .br_taken(br_taken), .ret_req(ret_req),
        .rti(rti), .intr_req(intr_req), .pc_write(pc_write), .ir_write(ir_write),
        .imm_write(imm_write), .stall(stall), .pc_src(pc_src),
        .mem_addr_sel(mem_addr_sel), .push_pc(push_pc), .intr_ack(intr_ack),
        .in_isr(in_isr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got pw,iw,mw,st,src,asel,push,ack,isr=%b want=%b",
                     tag, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit mr, input bit hs, input bit tb,
                        input bit br, input bit rr, input bit ri, input bit ir,
                        input string tag);
        bit pw, iw, mw, st, push, ack, waiting, nisr;
        logic [2:0] src;
        logic [1:0] asel;
        int nph;
        @(negedge clk);
        rst = r; mem_ready = mr; hazard_stall = hs; dec_two_byte = tb;
        br_taken = br; ret_req = rr; rti = ri; intr_req = ir;
        #1;
        pw = 1'b0; iw = 1'b0; mw = 1'b0; push = 1'b0; ack = 1'b0;
        src = 3'd0; asel = 2'd0; nph = phase; nisr = isr_flg;
        waiting = (phase == 0) || (phase == 1) || (phase == 2 && tb);
        st = hs || (waiting && !mr);
        if (phase == 0) begin
            asel = 2'd2;
            if (mr) begin pw = 1'b1; src = 3'd4; nph = 1; end
        end else if (phase == 1) begin
            if (ir && !isr_flg) nph = 4;
            else if (mr && !hs) begin iw = 1'b1; nph = 2; end
        end else if (phase == 2) begin
            if (tb) begin
                asel = 2'd1;
                if (mr && !hs) begin mw = 1'b1; nph = 3; end
            end else if (!hs) nph = 3;
        end else if (phase == 3) begin
            if (!hs) begin
                pw = 1'b1; nph = 1;
                src = rr ? 3'd3 : br ? 3'd2 : tb ? 3'd1 : 3'd0;
                if (rr && ri) nisr = 1'b0;
            end
        end else if (phase == 4) begin
            push = 1'b1; ack = 1'b1; nph = 5;
        end else begin
            pw = 1'b1; src = 3'd5; nisr = 1'b1; nph = 1;
        end
        if (r) begin
            check_eq(tag, {pc_write, ir_write, imm_write, stall, pc_src, mem_addr_sel,
                           push_pc, intr_ack, in_isr}, 12'd0);
            nph = 0; nisr = 1'b0;
        end else begin
            check_eq(tag, {pc_write, ir_write, imm_write, stall, pc_src, mem_addr_sel,
                           push_pc, intr_ack, in_isr},
                     {pw, iw, mw, st, src, asel, push, ack, isr_flg});
        end
        @(posedge clk);
        phase = nph; isr_flg = nisr; cyc++;
    endtask

    initial begin
        //    r  mr hs tb br rr ri ir
        step(1, 1, 0, 0, 0, 0, 0, 0, "reset");
        step(1, 1, 0, 0, 0, 0, 0, 0, "reset");
        // 1-byte program
        step(0, 1, 0, 0, 0, 0, 0, 0, "rstvec");
        step(0, 1, 0, 0, 0, 0, 0, 0, "fetch1");
        step(0, 1, 0, 0, 0, 0, 0, 0, "decode1");
        step(0, 1, 0, 0, 0, 0, 0, 0, "exec1");
        // 2-byte with memory wait in decode
        step(0, 1, 0, 1, 0, 0, 0, 0, "fetch2");
        step(0, 0, 0, 1, 0, 0, 0, 0, "imm_wait");
        step(0, 0, 0, 1, 0, 0, 0, 0, "imm_wait");
        step(0, 1, 0, 1, 0, 0, 0, 0, "imm_load");
        step(0, 1, 0, 1, 0, 0, 0, 0, "exec2");
        // branch and return together, then branch alone
        step(0, 1, 0, 0, 0, 0, 0, 0, "fetch");
        step(0, 1, 0, 0, 0, 0, 0, 0, "decode");
        step(0, 1, 0, 0, 1, 1, 0, 0, "exec_br_ret");
        step(0, 1, 0, 0, 0, 0, 0, 0, "fetch");
        step(0, 1, 0, 0, 0, 0, 0, 0, "decode");
        step(0, 1, 0, 0, 1, 0, 0, 0, "exec_br");
        // interrupt entry, nested request blocked, RTI, then retaken
        step(0, 1, 1, 0, 0, 0, 0, 1, "intr_fetch");
        step(0, 1, 0, 0, 0, 0, 0, 1, "intr_push");
        step(0, 1, 0, 0, 0, 0, 0, 1, "intr_vec");
        step(0, 1, 0, 0, 0, 0, 0, 1, "isr_fetch");
        step(0, 1, 0, 0, 0, 0, 0, 1, "isr_decode");
        step(0, 1, 0, 0, 0, 1, 1, 1, "isr_rti");
        step(0, 0, 0, 0, 0, 0, 0, 1, "intr_again");
        step(0, 1, 0, 0, 0, 0, 0, 0, "intr_push2");
        step(0, 1, 0, 0, 0, 0, 0, 0, "intr_vec2");
        // hazard held in execute
        step(0, 1, 0, 0, 0, 0, 0, 0, "fetch");
        step(0, 1, 0, 0, 0, 0, 0, 0, "decode");
        step(0, 1, 1, 0, 0, 0, 0, 0, "exec_hz");
        step(0, 1, 1, 0, 0, 0, 0, 0, "exec_hz");
        step(0, 1, 1, 0, 0, 0, 0, 0, "exec_hz");
        step(0, 1, 0, 0, 0, 0, 0, 0, "exec_release");
        // reset mid-decode
        step(0, 1, 0, 1, 0, 0, 0, 0, "fetch");
        step(1, 1, 0, 1, 0, 0, 0, 1, "rst_mid");
        step(0, 1, 0, 0, 0, 0, 0, 1, "restart");
        step(0, 1, 0, 0, 0, 0, 0, 0, "fetch");
        // randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(199) == 0, $urandom_range(3) != 0,
                 $urandom_range(4) == 0, $urandom_range(1) == 1,
                 $urandom_range(2) == 0, $urandom_range(3) == 0,
                 $urandom_range(1) == 1, $urandom_range(5) == 0, "random");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
